vga_timing_pattern_gen: RTL and testbench
=========================================

// Module: vga_timing_pattern_gen
// PURPOSE
//  Parametrised VGA timing generator with built-in monochrome test-pattern source.
//  Generalises the fixed 640x480 B/W VGA block: programmable H/V timings, sync polarity, pixel-clock divider, four patterns.
//  Exposes pixel coordinates and line/frame strobes so downstream pixel logic can align to it.
//  Sits between the system clock and the VGA pins.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch (pixels)
//  H_SYNC      96   hsync pulse width (pixels)
//  H_BP        48   horizontal back porch (pixels, >=1)
//  V_ACTIVE    480  visible lines per frame
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    vsync pulse width (lines)
//  V_BP        33   vertical back porch (lines, >=1)
//  HSYNC_POL   1    asserted level of hsync
//  VSYNC_POL   1    asserted level of vsync
//  CLK_DIV     1    clock cycles per pixel tick (>=1)
//  COUNT_W     11   counter width; 2^COUNT_W >= H_TOTAL and >= V_TOTAL
//  CHECK_LOG2  3    checkerboard square = 2^CHECK_LOG2 pixels
//  BAR_LOG2    6    vertical bar width = 2^BAR_LOG2 pixels
// PORTS
//  clk_25mhz    in   1        pixel/system clock
//  reset        in   1        asynchronous, active-low reset
//  pattern_sel  in   2        0 solid, 1 checker, 2 bars, 3 border
//  hsync        out  1        horizontal sync (polarity HSYNC_POL)
//  vsync        out  1        vertical sync (polarity VSYNC_POL)
//  video        out  1        monochrome pixel, 0 outside active area
//  active       out  1        1 when h_count<H_ACTIVE and v_count<V_ACTIVE
//  h_count      out  COUNT_W  current pixel column, 0..H_TOTAL-1
//  v_count      out  COUNT_W  current line, 0..V_TOTAL-1
//  pix_tick     out  1        1 on cycles where position advances at next edge
//  line_start   out  1        1 while h_count==0 (one pixel period)
//  frame_start  out  1        1 while h_count==0 and v_count==0 (one pixel period)
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//  - Divider div counts 0..CLK_DIV-1; pix_tick = (div==CLK_DIV-1); CLK_DIV=1 -> pix_tick always 1.
//  - On clock edge with pix_tick: h_count wraps H_TOTAL-1->0 and then v_count increments, wrapping V_TOTAL-1->0.
//  - All outputs registered, aligned with h_count/v_count (same cycle decode, zero skew between them).
//  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (656..751), else ~HSYNC_POL.
//  - vsync = VSYNC_POL when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (490..491), else ~VSYNC_POL.
//  - video (only when active, else 0): sel0 1; sel1 ~(h[CHECK_LOG2]^v[CHECK_LOG2]);
//    sel2 h[BAR_LOG2]; sel3 1 iff h==0|h==H_ACTIVE-1|v==0|v==V_ACTIVE-1.
//  - pattern_sel captured into internal reg only on the tick that enters (0,0); never changes mid-frame.
//  - Reset (async, reset==0): div=0, h_count=H_TOTAL-1, v_count=V_TOTAL-1, pattern reg=0;
//    hsync=~HSYNC_POL, vsync=~VSYNC_POL, video=0, active=0, line_start=0, frame_start=0.
//  - First pix_tick after reset release enters (0,0): frame_start=line_start=1, active=1, video per sel 0.
//  - Reset asserted mid-frame: immediate return to reset values; no partial sync pulse held.
// TESTING
//  - Reset, CLK_DIV=1: after release, frame_start at first edge; h_count 0->799->0, line = 800 clks (32 us @40 ns).
//  - hsync: asserted exactly h_count 656..751 (96 clks), deasserted at 752; vsync asserted v_count 490..491 only.
//  - Frame: frame_start pulses every 420000 clks; active count per frame = 307200.
//  - pattern_sel=1: video(0,0)=1, (8,0)=0, (8,8)=1; pattern_sel=2: video(63,y)=0, (64,y)=1; video=0 at h=640.
//  - Change pattern_sel mid-frame at v_count=100 -> video unchanged until next frame_start, then new pattern.
//  - CLK_DIV=2, HSYNC_POL=0: pix_tick every 2nd clk, line = 1600 clks, hsync low for 192 clks; async reset mid-line -> all outputs to reset values same cycle.

Source files
------------

// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with programmable porches, sync polarity and pixel divider.
// Drives a monochrome test pattern, latched only at frame start.
module vga_timing_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b1,
  parameter bit VSYNC_POL  = 1'b1,
  parameter int CLK_DIV    = 1,
  parameter int COUNT_W    = 11,
  parameter int CHECK_LOG2 = 3,
  parameter int BAR_LOG2   = 6
) (
  input  logic               clk_25mhz,
  input  logic               reset,
  input  logic [1:0]         pattern_sel,
  output logic               hsync,
  output logic               vsync,
  output logic               video,
  output logic               active,
  output logic [COUNT_W-1:0] h_count,
  output logic [COUNT_W-1:0] v_count,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [COUNT_W-1:0] h_q, h_d;
  logic [COUNT_W-1:0] v_q, v_d;
  logic [1:0]         pat_q, pat_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               vid_q, vid_d;
  logic               act_q, act_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;
  logic               pat_px;

  assign pix_tick = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_d = pix_tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (pix_tick) begin
      if (h_q == COUNT_W'(H_TOTAL - 1)) begin
        h_d = '0;
        if (v_q == COUNT_W'(V_TOTAL - 1)) v_d = '0;
        else                              v_d = v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    fs_d  = (h_d == '0) && (v_d == '0);
    ls_d  = (h_d == '0);
    pat_d = (pix_tick && fs_d) ? pattern_sel : pat_q;
  end

  // Decode the next position so outputs land in the same cycle as the counters.
  always_comb begin
    act_d = (h_d < COUNT_W'(H_ACTIVE)) && (v_d < COUNT_W'(V_ACTIVE));
    hs_d  = (h_d >= COUNT_W'(HS_BEG) && h_d < COUNT_W'(HS_END))
            ? HSYNC_POL : ~HSYNC_POL;
    vs_d  = (v_d >= COUNT_W'(VS_BEG) && v_d < COUNT_W'(VS_END))
            ? VSYNC_POL : ~VSYNC_POL;
    pat_px = 1'b0;
    unique case (pat_d)
      2'd0: pat_px = 1'b1;
      2'd1: pat_px = ~(h_d[CHECK_LOG2] ^ v_d[CHECK_LOG2]);
      2'd2: pat_px = h_d[BAR_LOG2];
      2'd3: pat_px = (h_d == '0) || (h_d == COUNT_W'(H_ACTIVE - 1)) ||
                     (v_d == '0) || (v_d == COUNT_W'(V_ACTIVE - 1));
    endcase
    vid_d = act_d & pat_px;
  end

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      h_q   <= COUNT_W'(H_TOTAL - 1);
      v_q   <= COUNT_W'(V_TOTAL - 1);
      pat_q <= '0;
      hs_q  <= ~HSYNC_POL;
      vs_q  <= ~VSYNC_POL;
      vid_q <= 1'b0;
      act_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      pat_q <= pat_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      vid_q <= vid_d;
      act_q <= act_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video       = vid_q;
  assign active      = act_q;
  assign h_count     = h_q;
  assign v_count     = v_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen: two small-geometry instances checked
// every cycle against a tick-count reference model.
module tb_vga_timing_pattern_gen;

  localparam int AHA = 40, AHF = 4, AHS = 8, AHB = 6;
  localparam int AVA = 20, AVF = 2, AVS = 3, AVB = 4;
  localparam int AD  = 1, ACL = 2, ACB = 3;
  localparam int AHT = AHA + AHF + AHS + AHB;
  localparam int AVT = AVA + AVF + AVS + AVB;

  localparam int BHA = 24, BHF = 3, BHS = 5, BHB = 4;
  localparam int BVA = 12, BVF = 2, BVS = 2, BVB = 3;
  localparam int BD  = 2, BCL = 1, BCB = 2;
  localparam int BHT = BHA + BHF + BHS + BHB;
  localparam int BVT = BVA + BVF + BVS + BVB;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [1:0] psel;

  logic       hs_a, vs_a, vid_a, act_a, tk_a, ls_a, fs_a;
  logic [6:0] h_a, v_a;
  logic       hs_b, vs_b, vid_b, act_b, tk_b, ls_b, fs_b;
  logic [5:0] h_b, v_b;

  int n_chk  = 0;
  int n_fail = 0;
  int k_a = 0, k_b = 0;
  int mp_a = 0, mp_b = 0;

  always #5 clk = ~clk;

  vga_timing_pattern_gen #(
    .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(AD),
    .COUNT_W(7), .CHECK_LOG2(ACL), .BAR_LOG2(ACB)
  ) u_a (
    .clk_25mhz(clk), .reset(rst_a), .pattern_sel(psel),
    .hsync(hs_a), .vsync(vs_a), .video(vid_a), .active(act_a),
    .h_count(h_a), .v_count(v_a), .pix_tick(tk_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_pattern_gen #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(BD),
    .COUNT_W(6), .CHECK_LOG2(BCL), .BAR_LOG2(BCB)
  ) u_b (
    .clk_25mhz(clk), .reset(rst_b), .pattern_sel(psel),
    .hsync(hs_b), .vsync(vs_b), .video(vid_b), .active(act_b),
    .h_count(h_b), .v_count(v_b), .pix_tick(tk_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail < 40)
        $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Position follows from the number of pixel ticks since reset release.
  function automatic logic [31:0] model(
    input int ha, hf, hs, hb, va, vf, vs, vb,
    input bit hp, vp, input int d, cl, cb, k, pat);
    int ht, vt, t, lin, h, v;
    bit act, vid, hsy, vsy, tick;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    t    = k / d;
    lin  = (ht * vt - 1 + t) % (ht * vt);
    h    = lin % ht;
    v    = lin / ht;
    act  = (h < ha) && (v < va);
    hsy  = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
    vsy  = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
    tick = (k % d) == d - 1;
    case (pat)
      0:       vid = 1'b1;
      1:       vid = !(((h >> cl) & 1) != ((v >> cl) & 1));
      2:       vid = ((h >> cb) & 1) == 1;
      default: vid = (h == 0) || (h == ha - 1) || (v == 0) || (v == va - 1);
    endcase
    vid = vid && act;
    return {9'd0, hsy, vsy, vid, act, tick, h == 0, lin == 0,
            8'(h), 8'(v)};
  endfunction

  always @(posedge clk) begin
    if (!rst_a) begin
      k_a = 0; mp_a = 0;
    end else begin
      if ((k_a % AD) == AD - 1 &&
          (AHT * AVT - 1 + (k_a + 1) / AD) % (AHT * AVT) == 0)
        mp_a = int'(psel);
      k_a++;
    end
    if (!rst_b) begin
      k_b = 0; mp_b = 0;
    end else begin
      if ((k_b % BD) == BD - 1 &&
          (BHT * BVT - 1 + (k_b + 1) / BD) % (BHT * BVT) == 0)
        mp_b = int'(psel);
      k_b++;
    end
  end

  always @(negedge clk) begin
    check("cyc_a",
          {9'd0, hs_a, vs_a, vid_a, act_a, tk_a, ls_a, fs_a,
           8'(h_a), 8'(v_a)},
          model(AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, 1'b1, 1'b1,
                AD, ACL, ACB, rst_a ? k_a : 0, rst_a ? mp_a : 0));
    check("cyc_b",
          {9'd0, hs_b, vs_b, vid_b, act_b, tk_b, ls_b, fs_b,
           8'(h_b), 8'(v_b)},
          model(BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b0, 1'b0,
                BD, BCL, BCB, rst_b ? k_b : 0, rst_b ? mp_b : 0));
  end

  initial begin
    int n, na, nlow;
    bit seen, prev;
    rst_a = 1'b0;
    rst_b = 1'b0;
    psel  = 2'd0;
    repeat (3) @(negedge clk);
    #1 check("rst_h_a", 32'(h_a), AHT - 1);
    check("rst_v_b", 32'(v_b), BVT - 1);
    check("rst_hs_b", 32'(hs_b), 1);
    @(negedge clk);
    #2 rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    check("first_fs_a", 32'(fs_a), 1);
    check("first_act_a", 32'(act_a), 1);
    check("first_vid_a", 32'(vid_a), 1);
    check("first_tick_b", 32'(tk_b), 1);

    // Random pattern changes at arbitrary points, usually mid-frame.
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) begin
        #2 psel = 2'($urandom_range(0, 3));
      end
    end

    // Frame period and active-pixel count on instance A.
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = fs_a;
    end
    check("fs_found_a", 32'(seen), 1);
    n = 0; na = 0; seen = 0;
    while (!seen && n < 3000) begin
      na += int'(act_a);
      @(negedge clk);
      n++;
      seen = fs_a;
    end
    check("frame_clks_a", n, AHT * AVT);
    check("active_cnt_a", na, AHA * AVA);

    // Line period and hsync width on instance B.
    prev = 1'b1; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = ls_b && !prev;
      prev = ls_b;
    end
    check("ls_found_b", 32'(seen), 1);
    n = 0; nlow = 0; seen = 0;
    while (!seen && n < 200) begin
      nlow += int'(!hs_b);
      @(negedge clk);
      n++;
      seen = ls_b && !prev;
      prev = ls_b;
    end
    check("line_clks_b", n, BHT * BD);
    check("hs_low_clks_b", nlow, BHS * BD);

    // Asynchronous reset while hsync is asserted.
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = !hs_b;
    end
    check("hs_on_b", 32'(hs_b), 0);
    #2 rst_b = 1'b0;
    #1 check("arst_hs_b", 32'(hs_b), 1);
    check("arst_vs_b", 32'(vs_b), 1);
    check("arst_act_b", 32'(act_b), 0);
    check("arst_vid_b", 32'(vid_b), 0);
    check("arst_ls_b", 32'(ls_b), 0);
    check("arst_fs_b", 32'(fs_b), 0);
    check("arst_h_b", 32'(h_b), BHT - 1);
    check("arst_v_b", 32'(v_b), BVT - 1);
    repeat (3) @(negedge clk);
    #2 rst_b = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) begin
        #2 psel = 2'($urandom_range(0, 3));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
